sram_arbiter: RTL and testbench

// - Shares the single-port on-chip SRAM between two requesters: port 0 (vector unit, vproc_mem_*) and port 1 (scalar/host side).
// - Fixed-priority-on-reset round-robin arbiter with fixed-latency response return.
// - Checks address range and alignment; flags bad accesses as errors without touching SRAM.
// - Sits between vproc_top/host and sram inside toplevel; replaces direct vproc-to-sram wiring.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/sram_arbiter_if.sv | 43 ++++
 rtl/mem_arb_rsp_pipe.sv | 39 +++
 rtl/sram_arbiter.sv | 104 ++++++++++
 tb/tb_sram_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: port ids, response tags and
// the address legality rule used at accept time.
package mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic {
        PORT_VPROC = 1'b0,
        PORT_HOST  = 1'b1
    } port_e;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  err;
        logic  rd;
    } rsp_tag_t;

    // Word aligned and below 4*2**sram_aw bytes, i.e. no bits above the SRAM word index.
    function automatic logic addr_legal(input logic [63:0] addr, input int sram_aw);
        addr_legal = (addr[1:0] == 2'b00) && ((addr >> (sram_aw + 2)) == 64'd0);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and SRAM-side signals of the arbiter, one bit/lane per port
// for the requester signals.
interface sram_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 10
);
    import mem_arb_pkg::*;

    logic [NUM_PORTS-1:0]                req;
    logic [NUM_PORTS-1:0]                gnt;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]    addr;
    logic [NUM_PORTS-1:0]                we;
    logic [NUM_PORTS-1:0][DATA_W/8-1:0]  be;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    wdata;
    logic [NUM_PORTS-1:0]                rvalid;
    logic [NUM_PORTS-1:0]                err;
    logic [NUM_PORTS-1:0][DATA_W-1:0]    rdata;

    logic                sram_cs;
    logic                sram_we;
    logic [DATA_W/8-1:0] sram_be;
    logic [SRAM_AW-1:0]  sram_addr;
    logic [DATA_W-1:0]   sram_wdata;
    logic [DATA_W-1:0]   sram_rdata;

    modport master (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata, sram_rdata,
        output gnt, rvalid, err, rdata,
        output sram_cs, sram_we, sram_be, sram_addr, sram_wdata
    );

    modport mem (
        input  sram_cs, sram_we, sram_be, sram_addr, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/mem_arb_rsp_pipe.sv
// Response tag delay line matching the SRAM read latency; a synchronous
// clear drops every in-flight response.
module mem_arb_rsp_pipe
    import mem_arb_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  rsp_tag_t acc_tag,
    output rsp_tag_t rsp_tag,
    output logic     busy
);

    rsp_tag_t stage [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= acc_tag;
            for (int i = 1; i < LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            busy = busy | stage[i].valid;
        end
    end

    assign rsp_tag = stage[LAT-1];

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between the vector unit
// (port 0) and the host (port 1), with fixed-latency in-order responses.
//
// state      | meaning
// PORT_VPROC | port 0 wins when both request (reset value)
// PORT_HOST  | port 1 wins when both request
module sram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SRAM_AW  = 10,
    parameter int SRAM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.slave  bus,
    output logic           busy
);

    port_e    prefer;
    port_e    prefer_next;
    port_e    sel;
    logic     any_gnt;
    logic     legal;
    logic     pipe_busy;
    rsp_tag_t acc_tag;
    rsp_tag_t rsp_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            prefer <= PORT_VPROC;
        end else begin
            prefer <= prefer_next;
        end
    end

    always_comb begin
        sel         = prefer;
        any_gnt     = 1'b0;
        prefer_next = prefer;
        bus.gnt     = '0;
        if (!rst) begin
            if (bus.req[PORT_VPROC] && bus.req[PORT_HOST]) begin
                sel     = prefer;
                any_gnt = 1'b1;
            end else if (bus.req[PORT_VPROC]) begin
                sel     = PORT_VPROC;
                any_gnt = 1'b1;
            end else if (bus.req[PORT_HOST]) begin
                sel     = PORT_HOST;
                any_gnt = 1'b1;
            end
        end
        if (any_gnt) begin
            bus.gnt[sel] = 1'b1;
            prefer_next  = (sel == PORT_VPROC) ? PORT_HOST : PORT_VPROC;
        end
    end

    // Illegal accesses still take a grant and a response slot, but never reach the SRAM.
    always_comb begin
        legal          = addr_legal(64'(bus.addr[sel]), SRAM_AW);
        bus.sram_cs    = any_gnt & legal;
        bus.sram_we    = bus.sram_cs & bus.we[sel];
        bus.sram_be    = bus.sram_cs ? bus.be[sel] : '0;
        bus.sram_addr  = bus.addr[sel][SRAM_AW+1:2];
        bus.sram_wdata = bus.wdata[sel];
    end

    always_comb begin
        acc_tag.valid = any_gnt;
        acc_tag.port  = sel;
        acc_tag.err   = ~legal;
        acc_tag.rd    = ~bus.we[sel];
    end

    mem_arb_rsp_pipe #(
        .LAT (SRAM_LAT)
    ) u_rsp_pipe (
        .clk     (clk),
        .rst     (rst),
        .acc_tag (acc_tag),
        .rsp_tag (rsp_tag),
        .busy    (pipe_busy)
    );

    // Gating with rst drops the response that would otherwise appear during the reset cycle.
    always_comb begin
        bus.rvalid = '0;
        bus.err    = '0;
        bus.rdata  = '0;
        if (rsp_tag.valid && !rst) begin
            bus.rvalid[rsp_tag.port] = 1'b1;
            bus.err[rsp_tag.port]    = rsp_tag.err;
            if (rsp_tag.rd && !rsp_tag.err) begin
                bus.rdata[rsp_tag.port] = bus.sram_rdata;
            end
        end
    end

    assign busy = pipe_busy & ~rst;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: behavioural SRAM, reference memory and
// a response scoreboard filled at grant time and drained at response time.
module tb_sram_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int SRAM_AW  = 10;
    localparam int SRAM_LAT = 1;
    localparam int WORDS    = 1 << SRAM_AW;

    typedef struct {
        int          due;
        int          port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        int          p;
        logic [31:0] a;
        logic        w;
        logic [3:0]  be;
        logic [31:0] d;
        logic        cs;
    } acc_t;

    logic clk;
    logic rst;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    exp_t        sb [$];
    logic [31:0] sram_mem [WORDS];
    logic [31:0] ref_mem  [WORDS];

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRAM_AW(SRAM_AW)) bus ();

    sram_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .SRAM_AW  (SRAM_AW),
        .SRAM_LAT (SRAM_LAT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // One-cycle-latency SRAM
    always @(posedge clk) begin
        if (bus.sram_cs) begin
            if (bus.sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.sram_be[b]) sram_mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
                end
            end else begin
                bus.sram_rdata <= sram_mem[bus.sram_addr];
            end
        end
    end

    // Response scoreboard
    exp_t       mon_e;
    logic [1:0] mon_v;
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due == cycle) begin
            mon_e = sb.pop_front();
            mon_v = 2'b00;
            mon_v[mon_e.port] = 1'b1;
            checks++;
            if (bus.rvalid !== mon_v) begin
                errors++;
                $display("FAIL rsp_rvalid cycle %0d: rvalid=%b required %b", cycle, bus.rvalid, mon_v);
            end
            checks++;
            if (bus.err[mon_e.port] !== mon_e.err) begin
                errors++;
                $display("FAIL rsp_err cycle %0d port %0d: err=%b required %b", cycle, mon_e.port, bus.err[mon_e.port], mon_e.err);
            end
            checks++;
            if (bus.rdata[mon_e.port] !== mon_e.rdata) begin
                errors++;
                $display("FAIL rsp_rdata cycle %0d port %0d: rdata=%h required %h", cycle, mon_e.port, bus.rdata[mon_e.port], mon_e.rdata);
            end
            checks++;
            if (bus.rdata[1-mon_e.port] !== 32'h0 || bus.err[1-mon_e.port] !== 1'b0) begin
                errors++;
                $display("FAIL rsp_other cycle %0d: other port rdata=%h err=%b required 0/0", cycle, bus.rdata[1-mon_e.port], bus.err[1-mon_e.port]);
            end
        end else begin
            checks++;
            if (bus.rvalid !== 2'b00) begin
                errors++;
                $display("FAIL rsp_unexpected cycle %0d: rvalid=%b required 00", cycle, bus.rvalid);
            end
        end
    end

    // Requesters must hold req until granted (reset excepted)
    logic [1:0] prev_req = 2'b00;
    logic [1:0] prev_gnt = 2'b00;
    logic       prev_rst = 1'b1;
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (!rst && !prev_rst && prev_req[p] && !prev_gnt[p]) begin
                checks++;
                if (bus.req[p] !== 1'b1) begin
                    errors++;
                    $display("FAIL req_stable port %0d: req=%b required 1", p, bus.req[p]);
                end
            end
        end
        prev_req <= bus.req;
        prev_gnt <= bus.gnt;
        prev_rst <= rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [31:0] a, input logic w,
                            input logic [3:0] be, input logic [31:0] d);
        bus.addr[p]  = a;
        bus.we[p]    = w;
        bus.be[p]    = be;
        bus.wdata[p] = d;
    endtask

    // Reference model: applies legal writes and queues the expected response
    task automatic expect_access(input int p, input logic [31:0] a, input logic w,
                                 input logic [3:0] be, input logic [31:0] d);
        exp_t e;
        logic legal;
        int   idx;
        legal = (a[1:0] == 2'b00) && (a < 32'(4 * WORDS));
        idx   = int'(a[SRAM_AW+1:2]);
        if (legal && w) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        e.due   = cycle + SRAM_LAT;
        e.port  = p;
        e.err   = ~legal;
        e.rdata = (legal && !w) ? ref_mem[idx] : 32'h0;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.req = 2'b11;
        set_port(0, 32'h0, 1'b0, 4'hF, 32'h0);
        set_port(1, 32'h4, 1'b0, 4'hF, 32'h0);
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: gnt=%b required 00", bus.gnt); end
        checks++;
        if (bus.sram_cs !== 1'b0 || bus.sram_we !== 1'b0) begin
            errors++; $display("FAIL reset_sram: cs=%b we=%b required 0/0", bus.sram_cs, bus.sram_we);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b required 0", busy); end
        checks++;
        if (bus.rdata !== '0 || bus.err !== 2'b00) begin
            errors++; $display("FAIL reset_rsp: rdata=%h err=%b required 0", bus.rdata, bus.err);
        end
        tick();
        rst     = 1'b0;
        bus.req = 2'b00;
        tick();
    endtask

    task automatic test_single_rw();
        acc_t       tbl [$];
        logic [1:0] exp_g;
        tbl.push_back('{0, 32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1});
        tbl.push_back('{0, 32'h0000_0010, 1'b0, 4'hF, 32'h0,         1'b1});
        foreach (tbl[i]) begin
            tick();
            set_port(tbl[i].p, tbl[i].a, tbl[i].w, tbl[i].be, tbl[i].d);
            exp_g = (tbl[i].p == 0) ? 2'b01 : 2'b10;
            bus.req = exp_g;
            @(negedge clk);
            checks++;
            if (bus.gnt !== exp_g) begin errors++; $display("FAIL single_gnt %0d: gnt=%b required %b", i, bus.gnt, exp_g); end
            checks++;
            if (bus.sram_cs !== tbl[i].cs) begin errors++; $display("FAIL single_cs %0d: cs=%b required %b", i, bus.sram_cs, tbl[i].cs); end
            checks++;
            if (bus.sram_addr !== 10'h004) begin errors++; $display("FAIL single_addr %0d: sram_addr=%h required 004", i, bus.sram_addr); end
            expect_access(tbl[i].p, tbl[i].a, tbl[i].w, tbl[i].be, tbl[i].d);
        end
        tick();
        bus.req = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.rdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: rdata=%h required deadbeef", bus.rdata[0]); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_on: busy=%b required 1", busy); end
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_off: busy=%b required 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        int         p;
        tick();
        set_port(0, 32'h100, 1'b1, 4'hF, 32'h1111_0000);
        bus.req = 2'b01;
        @(negedge clk);
        expect_access(0, 32'h100, 1'b1, 4'hF, 32'h1111_0000);
        tick();
        set_port(1, 32'h200, 1'b1, 4'hF, 32'h2222_0001);
        bus.req = 2'b10;
        @(negedge clk);
        expect_access(1, 32'h200, 1'b1, 4'hF, 32'h2222_0001);
        for (int i = 0; i < 6; i++) begin
            tick();
            set_port(0, 32'h100, 1'b0, 4'hF, 32'h0);
            set_port(1, 32'h200, 1'b0, 4'hF, 32'h0);
            bus.req = 2'b11;
            @(negedge clk);
            p = i % 2;
            exp_g = (p == 0) ? 2'b01 : 2'b10;
            checks++;
            if (bus.gnt !== exp_g) begin errors++; $display("FAIL rr_gnt %0d: gnt=%b required %b", i, bus.gnt, exp_g); end
            expect_access(p, (p == 0) ? 32'h100 : 32'h200, 1'b0, 4'hF, 32'h0);
        end
        tick();
        bus.req = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rr_tail_gnt: gnt=%b required 01", bus.gnt); end
        expect_access(0, 32'h100, 1'b0, 4'hF, 32'h0);
        tick();
        bus.req = 2'b00;
    endtask

    task automatic test_addr_errors();
        acc_t tbl [$];
        tbl.push_back('{1, 32'h0000_1000, 1'b0, 4'hF, 32'h0,         1'b0});
        tbl.push_back('{1, 32'h8000_0000, 1'b1, 4'hF, 32'h5A5A_5A5A, 1'b0});
        tbl.push_back('{1, 32'h0000_0FFC, 1'b1, 4'hF, 32'h1234_5678, 1'b1});
        tbl.push_back('{1, 32'h0000_0FFC, 1'b0, 4'hF, 32'h0,         1'b1});
        foreach (tbl[i]) begin
            tick();
            set_port(tbl[i].p, tbl[i].a, tbl[i].w, tbl[i].be, tbl[i].d);
            bus.req = 2'b10;
            @(negedge clk);
            checks++;
            if (bus.gnt !== 2'b10) begin errors++; $display("FAIL range_gnt %0d: gnt=%b required 10", i, bus.gnt); end
            checks++;
            if (bus.sram_cs !== tbl[i].cs) begin errors++; $display("FAIL range_cs %0d: cs=%b required %b", i, bus.sram_cs, tbl[i].cs); end
            if (tbl[i].cs) begin
                checks++;
                if (bus.sram_addr !== 10'h3FF) begin errors++; $display("FAIL range_addr %0d: sram_addr=%h required 3ff", i, bus.sram_addr); end
            end
            expect_access(tbl[i].p, tbl[i].a, tbl[i].w, tbl[i].be, tbl[i].d);
        end
        tick();
        bus.req = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.rdata[1] !== 32'h1234_5678) begin errors++; $display("FAIL range_top_rdata: rdata=%h required 12345678", bus.rdata[1]); end
    endtask

    task automatic test_partial_write();
        acc_t tbl [$];
        tbl.push_back('{0, 32'h0000_0022, 1'b1, 4'hF, 32'h0BAD_0BAD, 1'b0});
        tbl.push_back('{0, 32'h0000_0040, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1});
        tbl.push_back('{0, 32'h0000_0040, 1'b1, 4'h3, 32'hAAAA_5555, 1'b1});
        tbl.push_back('{0, 32'h0000_0040, 1'b0, 4'hF, 32'h0,         1'b1});
        tbl.push_back('{0, 32'h0000_0040, 1'b1, 4'h0, 32'h0000_0000, 1'b1});
        tbl.push_back('{0, 32'h0000_0040, 1'b0, 4'hF, 32'h0,         1'b1});
        foreach (tbl[i]) begin
            tick();
            set_port(tbl[i].p, tbl[i].a, tbl[i].w, tbl[i].be, tbl[i].d);
            bus.req = 2'b01;
            @(negedge clk);
            checks++;
            if (bus.gnt !== 2'b01) begin errors++; $display("FAIL pw_gnt %0d: gnt=%b required 01", i, bus.gnt); end
            checks++;
            if (bus.sram_cs !== tbl[i].cs) begin errors++; $display("FAIL pw_cs %0d: cs=%b required %b", i, bus.sram_cs, tbl[i].cs); end
            if (tbl[i].cs && tbl[i].w) begin
                checks++;
                if (bus.sram_we !== 1'b1 || bus.sram_be !== tbl[i].be) begin
                    errors++; $display("FAIL pw_be %0d: we=%b be=%h required 1/%h", i, bus.sram_we, bus.sram_be, tbl[i].be);
                end
            end
            expect_access(tbl[i].p, tbl[i].a, tbl[i].w, tbl[i].be, tbl[i].d);
        end
        tick();
        bus.req = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.rdata[0] !== 32'hFFFF_5555) begin errors++; $display("FAIL pw_rdata: rdata=%h required ffff5555", bus.rdata[0]); end
    endtask

    task automatic test_reset_mid();
        tick();
        set_port(0, 32'h10, 1'b0, 4'hF, 32'h0);
        set_port(1, 32'h100, 1'b0, 4'hF, 32'h0);
        bus.req = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rst_pre_gnt: gnt=%b required 01", bus.gnt); end
        expect_access(0, 32'h10, 1'b0, 4'hF, 32'h0);
        tick();
        rst     = 1'b1;
        bus.req = 2'b11;
        sb.delete();
        @(negedge clk);
        checks++;
        if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid: rvalid=%b required 00", bus.rvalid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: busy=%b required 0", busy); end
        checks++;
        if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: gnt=%b required 00", bus.gnt); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b01) begin errors++; $display("FAIL rst_post_gnt: gnt=%b required 01", bus.gnt); end
        expect_access(0, 32'h10, 1'b0, 4'hF, 32'h0);
        tick();
        bus.req = 2'b10;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b10) begin errors++; $display("FAIL rst_second_gnt: gnt=%b required 10", bus.gnt); end
        expect_access(1, 32'h100, 1'b0, 4'hF, 32'h0);
        tick();
        bus.req = 2'b00;
    endtask

    task automatic test_back_to_back();
        tick();
        set_port(0, 32'h80, 1'b1, 4'hF, 32'hCAFE_F00D);
        bus.req = 2'b01;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b01) begin errors++; $display("FAIL b2b_wr_gnt: gnt=%b required 01", bus.gnt); end
        expect_access(0, 32'h80, 1'b1, 4'hF, 32'hCAFE_F00D);
        tick();
        set_port(1, 32'h80, 1'b0, 4'hF, 32'h0);
        bus.req = 2'b10;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 2'b10) begin errors++; $display("FAIL b2b_rd_gnt: gnt=%b required 10", bus.gnt); end
        expect_access(1, 32'h80, 1'b0, 4'hF, 32'h0);
        tick();
        bus.req = 2'b00;
        @(negedge clk);
        checks++;
        if (bus.rdata[1] !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_rdata: rdata=%h required cafef00d", bus.rdata[1]); end
    endtask

    initial begin
        rst        = 1'b1;
        bus.req    = 2'b00;
        bus.addr   = '0;
        bus.we     = 2'b00;
        bus.be     = '0;
        bus.wdata  = '0;
        test_reset();
        test_single_rw();
        test_round_robin();
        test_addr_errors();
        test_partial_write();
        test_reset_mid();
        test_back_to_back();
        repeat (3) tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
